// File: rtl/dev_stage_pkg.sv
// Shared definitions for the development-stage arbiter: counter op
// encodings, FSM state type and the width of the derived stage value.
package dev_stage_pkg;

  localparam int STAGE_W = 2;

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_FAST = 2'b10,
    OP_SET  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/development_stage_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr,
// wrapping modulo N. The grant is onehot0.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;

  // Scan the requests starting at ptr and grant the first one found
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/development_stage_arbiter.sv
// Development-stage arbiter: grants one level-change request at a time,
// drives the level counter's one-cycle controls, tracks the stage and
// applies a hold after each stage change.
// Optional per-window step budget: define DEV_STAGE_ARB_RATE_LIMIT_EN.
module development_stage_arbiter
  import dev_stage_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int LEVEL_W   = 9,
  parameter int WINDOW    = 16,
  parameter int MAX_STEPS = 4,
  parameter int HOLD      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  output logic [NREQ-1:0]      req_ready,
  input  logic [LEVEL_W-1:0]   level,
  output logic                 inc,
  output logic                 dec,
  output logic                 fast,
  output logic                 setval,
  output logic [STAGE_W-1:0]   stage,
  output logic                 stage_changed,
  output logic                 busy
);

  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HOLD_W = $clog2(HOLD + 1);

  state_e              state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [NREQ-1:0]     setval_vec;
  logic [NREQ-1:0]     normal_vec;
  logic [NREQ-1:0]     set_grant;
  logic [NREQ-1:0]     rr_grant;
  logic [NREQ-1:0]     grant_vec;
  op_e                 win_op;
  logic                grant_any;
  logic                budget_ok;
  logic [STAGE_W-1:0]  level_stage;
  logic                unused_level_bits;

  assign level_stage       = level[LEVEL_W-1 -: STAGE_W];
  assign unused_level_bits = ^level[LEVEL_W-STAGE_W-1:0];

  // Split valid requests into setval ops and ordinary step ops
  always_comb begin
    setval_vec = '0;
    normal_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        if (req_op[2*i +: 2] == OP_SET) setval_vec[i] = 1'b1;
        else                            normal_vec[i] = 1'b1;
      end
    end
  end

  rr_arbiter #(.N(NREQ), .PW(PTR_W)) u_rr (
    .req   (normal_vec & {NREQ{budget_ok}}),
    .ptr   (rr_ptr),
    .grant (rr_grant)
  );

  // Lowest-index setval beats any step op
  assign set_grant = setval_vec & (~setval_vec + NREQ'(1));
  assign grant_vec = (|setval_vec) ? set_grant : rr_grant;

  // Grant only while idle, or setvals only while holding
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      if (state == ST_IDLE)      req_ready = grant_vec;
      else if (state == ST_HOLD) req_ready = set_grant;
    end
  end

  assign grant_any = |req_ready;

  // Encode the winner and fetch its op
  always_comb begin
    win_idx = '0;
    win_op  = OP_INC;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        win_idx = PTR_W'(i);
        win_op  = op_e'(req_op[2*i +: 2]);
      end
    end
  end

  assign next_ptr = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);

`ifdef DEV_STAGE_ARB_RATE_LIMIT_EN
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int BUD_W = $clog2(MAX_STEPS + 1);

  logic [WIN_W-1:0] window;
  logic [BUD_W-1:0] budget;
  logic             consume;

  assign budget_ok = (budget != '0);
  assign consume   = grant_any && (win_op != OP_SET);

  // Free-running window; budget reloads on wrap, then takes any same-cycle step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
      budget <= BUD_W'(MAX_STEPS);
    end else if (window == WIN_W'(WINDOW - 1)) begin
      window <= '0;
      budget <= consume ? BUD_W'(MAX_STEPS - 1) : BUD_W'(MAX_STEPS);
    end else begin
      window <= window + WIN_W'(1);
      if (consume) budget <= budget - BUD_W'(1);
    end
  end
`else
  assign budget_ok = 1'b1;
`endif

  // Main FSM: grant, issue one pulse, check stage, optionally hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      hold_cnt      <= '0;
      stage         <= '0;
      stage_changed <= 1'b0;
      inc           <= 1'b0;
      dec           <= 1'b0;
      fast          <= 1'b0;
      setval        <= 1'b0;
    end else begin
      inc           <= 1'b0;
      dec           <= 1'b0;
      fast          <= 1'b0;
      setval        <= 1'b0;
      stage_changed <= 1'b0;
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (grant_any) begin
            rr_ptr   <= next_ptr;
            hold_cnt <= '0;
            state    <= ST_ISSUE;
            case (win_op)
              OP_INC:  inc <= 1'b1;
              OP_DEC:  dec <= 1'b1;
              OP_FAST: begin
                inc  <= 1'b1;
                fast <= 1'b1;
              end
              OP_SET:  setval <= 1'b1;
            endcase
          end else if (state == ST_HOLD) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            if (hold_cnt == HOLD_W'(1)) state <= ST_IDLE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (level_stage != stage) begin
            stage         <= level_stage;
            stage_changed <= 1'b1;
            hold_cnt      <= HOLD_W'(HOLD);
            state         <= ST_HOLD;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_development_stage_arbiter.sv
// Self-checking bench for development_stage_arbiter. Expected grants are
// queued as stimulus is driven and compared as the DUT grants them.
// Rate-limit scenarios follow DEV_STAGE_ARB_RATE_LIMIT_EN.
module tb_development_stage_arbiter;
  import dev_stage_pkg::*;

  localparam int NREQ    = 3;
  localparam int LEVEL_W = 9;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [2*NREQ-1:0]  req_op;
  logic [NREQ-1:0]    req_ready;
  logic [LEVEL_W-1:0] level;
  logic               inc, dec, fast, setval;
  logic [1:0]         stage;
  logic               stage_changed;
  logic               busy;

  development_stage_arbiter #(
    .NREQ(NREQ), .LEVEL_W(LEVEL_W), .WINDOW(16), .MAX_STEPS(4), .HOLD(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_op        (req_op),
    .req_ready     (req_ready),
    .level         (level),
    .inc           (inc),
    .dec           (dec),
    .fast          (fast),
    .setval        (setval),
    .stage         (stage),
    .stage_changed (stage_changed),
    .busy          (busy)
  );

  typedef struct {
    int         idx;
    logic [3:0] pulses;
    int         cyc;
  } exp_t;

  exp_t       sbQueue[$];
  int         vectorCount = 0;
  int         failCount   = 0;
  int         tick        = 0;
  int         base        = 0;
  logic       pulsePending = 1'b0;
  logic [3:0] expPulse     = 4'b0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    tick++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag,
               observed, expected, tick - base);
    end
  endtask

  function automatic logic [3:0] pulseOf(input op_e op);
    case (op)
      OP_INC:  return 4'b1000;
      OP_DEC:  return 4'b0100;
      OP_FAST: return 4'b1010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic pushExpect(input int idx, input op_e op, input int cyc);
    exp_t e;
    e.idx    = idx;
    e.pulses = pulseOf(op);
    e.cyc    = cyc;
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(input int idx, input logic v, input op_e op);
    req_valid[idx]     = v;
    req_op[2*idx +: 2] = op;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic gotoCycle(input int n);
    while ((tick - base) < n) nextCycle();
  endtask

  task automatic applyReset();
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    level     = '0;
    nextCycle();
    nextCycle();
    rst  = 1'b0;
    base = tick;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while (sbQueue.size() != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    if (sbQueue.size() != 0) begin
      checkOutput("drain_timeout", 32'(sbQueue.size()), 32'd0);
      sbQueue.delete();
    end
    #1;
  endtask

  // Scoreboard monitor: pulses follow grants by one cycle, nothing else pulses
  initial forever begin
    exp_t       e;
    logic [3:0] pulses;
    @(negedge clk);
    if (rst) begin
      pulsePending = 1'b0;
    end else begin
      pulses = {inc, dec, fast, setval};
      if (pulsePending) begin
        checkOutput("pulse", 32'(pulses), 32'(expPulse));
        pulsePending = 1'b0;
      end else begin
        checkOutput("idle_pulse", 32'(pulses), 32'd0);
      end
      if (req_ready != '0) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_grant", 32'(req_ready), 32'd0);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("grant_idx", 32'(req_ready), 32'(1 << e.idx));
          if (e.cyc >= 0) checkOutput("grant_cycle", 32'(tick - base), 32'(e.cyc));
          expPulse     = e.pulses;
          pulsePending = 1'b1;
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    level     = '0;

    // Reset values, with a request present to show ready is held low
    nextCycle();
    req_valid = 3'b001;
    @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_pulses", 32'({inc, dec, fast, setval}), 32'd0);
    checkOutput("rst_stage", 32'(stage), 32'd0);
    checkOutput("rst_changed", 32'(stage_changed), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    nextCycle();

    // Single inc from requester 0
    applyReset();
    applyStimulus(0, 1'b1, OP_INC);
    pushExpect(0, OP_INC, 0);
    @(negedge clk);
    checkOutput("single_busy0", 32'(busy), 32'd0);
    gotoCycle(1);
    applyStimulus(0, 1'b0, OP_INC);
    @(negedge clk);
    checkOutput("single_busy1", 32'(busy), 32'd1);
    gotoCycle(2);
    @(negedge clk);
    checkOutput("single_busy2", 32'(busy), 32'd1);
    gotoCycle(3);
    @(negedge clk);
    checkOutput("single_busy3", 32'(busy), 32'd0);
    checkOutput("single_stage", 32'(stage), 32'd0);
    checkOutput("single_changed", 32'(stage_changed), 32'd0);
    waitDrain(10);

    // All three requesters inc continuously: strict rotation
    applyReset();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, OP_INC);
`ifdef DEV_STAGE_ARB_RATE_LIMIT_EN
    for (int g = 0; g < 8; g++) pushExpect(g % 3, OP_INC, (g / 4) * 16 + (g % 4) * 3);
`else
    for (int g = 0; g < 8; g++) pushExpect(g % 3, OP_INC, g * 3);
`endif
    waitDrain(60);
    req_valid = '0;
    gotoCycle((tick - base) + 3);

    // Setval from requester 2 beats inc from requester 1
    applyReset();
    applyStimulus(1, 1'b1, OP_INC);
    applyStimulus(2, 1'b1, OP_SET);
    pushExpect(2, OP_SET, 0);
    pushExpect(1, OP_INC, 3);
    gotoCycle(1);
    applyStimulus(2, 1'b0, OP_SET);
    waitDrain(20);
    applyStimulus(1, 1'b0, OP_INC);
    gotoCycle((tick - base) + 3);

    // Stage change, hold, and setval during hold
    applyReset();
    level = 9'd127;
    applyStimulus(0, 1'b1, OP_INC);
    pushExpect(0, OP_INC, 0);
    gotoCycle(1);
    applyStimulus(0, 1'b0, OP_INC);
    level = 9'd128;
    gotoCycle(3);
    @(negedge clk);
    checkOutput("hold_stage1", 32'(stage), 32'd1);
    checkOutput("hold_changed", 32'(stage_changed), 32'd1);
    checkOutput("hold_busy", 32'(busy), 32'd1);
    gotoCycle(4);
    applyStimulus(1, 1'b1, OP_DEC);
    pushExpect(1, OP_DEC, 11);
    @(negedge clk);
    checkOutput("hold_changed_once", 32'(stage_changed), 32'd0);
    gotoCycle(10);
    @(negedge clk);
    checkOutput("hold_busy_last", 32'(busy), 32'd1);
    waitDrain(20);
    applyStimulus(1, 1'b0, OP_DEC);
    gotoCycle(14);
    applyStimulus(2, 1'b1, OP_SET);
    pushExpect(2, OP_SET, 14);
    gotoCycle(15);
    applyStimulus(2, 1'b0, OP_SET);
    level = 9'd300;
    gotoCycle(17);
    @(negedge clk);
    checkOutput("hold_stage2", 32'(stage), 32'd2);
    checkOutput("hold_changed2", 32'(stage_changed), 32'd1);
    gotoCycle(18);
    applyStimulus(0, 1'b1, OP_SET);
    pushExpect(0, OP_SET, 18);
    gotoCycle(19);
    applyStimulus(0, 1'b0, OP_SET);
    gotoCycle(21);
    @(negedge clk);
    checkOutput("hold_abandon_busy", 32'(busy), 32'd0);
    checkOutput("hold_abandon_stage", 32'(stage), 32'd2);
    checkOutput("hold_abandon_changed", 32'(stage_changed), 32'd0);
    waitDrain(10);

`ifdef DEV_STAGE_ARB_RATE_LIMIT_EN
    // Budget exhausted: setval still granted, inc waits for the wrap
    applyReset();
    applyStimulus(0, 1'b1, OP_INC);
    pushExpect(0, OP_INC, 0);
    pushExpect(0, OP_INC, 3);
    pushExpect(0, OP_INC, 6);
    pushExpect(0, OP_INC, 9);
    pushExpect(2, OP_SET, 12);
    pushExpect(0, OP_INC, 16);
    pushExpect(0, OP_INC, 19);
    pushExpect(0, OP_INC, 22);
    pushExpect(0, OP_INC, 25);
    pushExpect(0, OP_INC, 32);
    gotoCycle(10);
    applyStimulus(2, 1'b1, OP_SET);
    gotoCycle(13);
    applyStimulus(2, 1'b0, OP_SET);
    waitDrain(60);
    applyStimulus(0, 1'b0, OP_INC);
    gotoCycle((tick - base) + 3);
`endif

    // Fast inc and dec pulse encodings
    applyReset();
    applyStimulus(0, 1'b1, OP_DEC);
    applyStimulus(2, 1'b1, OP_FAST);
    pushExpect(0, OP_DEC, 0);
    pushExpect(2, OP_FAST, 3);
    gotoCycle(1);
    applyStimulus(0, 1'b0, OP_DEC);
    waitDrain(20);
    applyStimulus(2, 1'b0, OP_FAST);
    gotoCycle((tick - base) + 3);

    // Reset in the ISSUE cycle aborts the pulse; request is re-granted
    applyReset();
    applyStimulus(0, 1'b1, OP_INC);
    pushExpect(0, OP_INC, 0);
    gotoCycle(1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_pulses", 32'({inc, dec, fast, setval}), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'(req_ready), 32'd0);
    checkOutput("abort_stage", 32'(stage), 32'd0);
    nextCycle();
    rst  = 1'b0;
    base = tick;
    pushExpect(0, OP_INC, 0);
    gotoCycle(1);
    applyStimulus(0, 1'b0, OP_INC);
    gotoCycle(3);
    @(negedge clk);
    checkOutput("regrant_idle", 32'(busy), 32'd0);
    waitDrain(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
